// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the SOPC memory arbiter.
// Also holds defaults reused by future bus bridges.
package mem_arbiter_pkg;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT_I = 2'd1,
        ST_GRANT_D = 2'd2,
        ST_RESP    = 2'd3
    } arb_state_e;

    localparam logic [3:0]  BYTE_SEL_ALL = 4'hF;
    localparam logic [63:0] ERR_DATA     = 64'd0;

    localparam int DEF_ADDR_W          = 32;
    localparam int DEF_DATA_W          = 32;
    localparam int DEF_TIMEOUT_CYC     = 16;
    localparam int DEF_MAX_DATA_STREAK = 2;
endpackage

// File: rtl/mem_arbiter_timeout_cnt.sv
// Clearable up-counter with a terminal-count flag; used as the grant
// watchdog in mem_arbiter and intended for reuse in bus bridges.
module arb_timeout_cnt #(
    parameter int WIDTH    = 5,
    parameter int TERMINAL = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             tc
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= count + WIDTH'(1);
    end

    assign tc = (count == WIDTH'(TERMINAL));
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port SOPC memory between instruction fetch and
// load/store, with a data-streak fairness limit and a grant timeout.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W          = DEF_ADDR_W,
    parameter int DATA_W          = DEF_DATA_W,
    parameter int TIMEOUT_CYC     = DEF_TIMEOUT_CYC,
    parameter int MAX_DATA_STREAK = DEF_MAX_DATA_STREAK
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    output logic              inst_ack_o,
    output logic [DATA_W-1:0] inst_rdata_o,
    input  logic              data_req_i,
    input  logic              data_we_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [DATA_W-1:0] data_wdata_i,
    input  logic [3:0]        data_sel_i,
    output logic              data_ack_o,
    output logic [DATA_W-1:0] data_rdata_o,
    output logic              err_o,
    output logic              stallreq_o,
    output logic              mem_ce_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [3:0]        mem_sel_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ready_i
);
    localparam int TO_W     = $clog2(TIMEOUT_CYC + 1);
    localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);

    arb_state_e          state, state_nxt;
    logic [STREAK_W-1:0] streak;
    logic [TO_W-1:0]     to_count;
    logic                to_tc;
    logic                in_grant, grant_i, grant_d, done;
    logic                streak_max;

    assign in_grant   = (state == ST_GRANT_I) || (state == ST_GRANT_D);
    assign streak_max = (streak == STREAK_W'(MAX_DATA_STREAK));

    arb_timeout_cnt #(
        .WIDTH    (TO_W),
        .TERMINAL (TIMEOUT_CYC - 1)
    ) u_timeout (
        .clk   (clk),
        .rst   (rst),
        .clr   (!in_grant),
        .en    (in_grant),
        .count (to_count),
        .tc    (to_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                // Data wins ties until it has starved fetch MAX_DATA_STREAK times.
                if (data_req_i && (!inst_req_i || !streak_max)) begin
                    grant_d   = 1'b1;
                    state_nxt = ST_GRANT_D;
                end else if (inst_req_i) begin
                    grant_i   = 1'b1;
                    state_nxt = ST_GRANT_I;
                end
            end
            ST_GRANT_I, ST_GRANT_D: begin
                if (mem_ready_i || to_tc) begin
                    done      = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            streak <= '0;
        else if (grant_i)
            streak <= '0;
        else if (grant_d && inst_req_i && !streak_max)
            streak <= streak + STREAK_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_ce_o     <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
            mem_sel_o    <= '0;
            inst_ack_o   <= 1'b0;
            data_ack_o   <= 1'b0;
            inst_rdata_o <= '0;
            data_rdata_o <= '0;
            err_o        <= 1'b0;
        end else begin
            inst_ack_o <= 1'b0;
            data_ack_o <= 1'b0;
            err_o      <= 1'b0;
            if (grant_i) begin
                mem_ce_o    <= 1'b1;
                mem_we_o    <= 1'b0;
                mem_addr_o  <= inst_addr_i;
                mem_wdata_o <= '0;
                mem_sel_o   <= BYTE_SEL_ALL;
            end else if (grant_d) begin
                mem_ce_o    <= 1'b1;
                mem_we_o    <= data_we_i;
                mem_addr_o  <= data_addr_i;
                mem_wdata_o <= data_wdata_i;
                mem_sel_o   <= data_sel_i;
            end else if (done) begin
                // Ready takes priority over a coincident timeout.
                mem_ce_o <= 1'b0;
                mem_we_o <= 1'b0;
                err_o    <= !mem_ready_i;
                if (state == ST_GRANT_I) begin
                    inst_ack_o   <= 1'b1;
                    inst_rdata_o <= mem_ready_i ? mem_rdata_i : ERR_DATA[DATA_W-1:0];
                end else begin
                    data_ack_o   <= 1'b1;
                    data_rdata_o <= mem_ready_i ? mem_rdata_i : ERR_DATA[DATA_W-1:0];
                end
            end
        end
    end

    assign stallreq_o = (inst_req_i | data_req_i) & (state != ST_RESP);
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: fetch, store, arbitration fairness,
// timeout abort and reset in the middle of an access.
module tb_mem_arbiter;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req_i, data_req_i, data_we_i, mem_ready_i;
    logic [31:0] inst_addr_i, data_addr_i, data_wdata_i, mem_rdata_i;
    logic [3:0]  data_sel_i;
    logic        inst_ack_o, data_ack_o, err_o, stallreq_o, mem_ce_o, mem_we_o;
    logic [31:0] inst_rdata_o, data_rdata_o, mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_sel_o;

    typedef struct {
        bit          is_inst;
        logic [31:0] rdata;
        bit          err;
    } exp_t;
    exp_t sb[$];

    int compared = 0;
    int mismatched = 0;

    mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TIMEOUT), .MAX_DATA_STREAK(2)
    ) dut (
        .clk(clk), .rst(rst),
        .inst_req_i(inst_req_i), .inst_addr_i(inst_addr_i),
        .inst_ack_o(inst_ack_o), .inst_rdata_o(inst_rdata_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i),
        .data_wdata_i(data_wdata_i), .data_sel_i(data_sel_i),
        .data_ack_o(data_ack_o), .data_rdata_o(data_rdata_o),
        .err_o(err_o), .stallreq_o(stallreq_o),
        .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_sel_o(mem_sel_o),
        .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One access on one port; wait_cyc==0 means memory never answers.
    task automatic run_single(input bit is_inst, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] sel,
                              input int wait_cyc, input logic [31:0] rd);
        exp_t e, got_e;
        int gcnt = 0;
        int lat = 0;
        int exp_g;
        bit got = 0;
        e.is_inst = is_inst;
        e.rdata   = (wait_cyc == 0) ? 32'h0 : rd;
        e.err     = (wait_cyc == 0);
        sb.push_back(e);
        exp_g = (wait_cyc == 0) ? TIMEOUT : wait_cyc;
        @(negedge clk);
        mem_rdata_i = rd;
        if (is_inst) begin
            inst_req_i = 1'b1; inst_addr_i = addr;
        end else begin
            data_req_i = 1'b1; data_we_i = we; data_addr_i = addr;
            data_wdata_i = wdata; data_sel_i = sel;
        end
        for (int c = 0; c < 64 && !got; c++) begin
            @(negedge clk);
            lat++;
            if (mem_ce_o) begin
                gcnt++;
                compared++;
                if (mem_addr_o !== addr || mem_we_o !== (is_inst ? 1'b0 : we) ||
                    mem_sel_o !== (is_inst ? 4'hF : sel) || stallreq_o !== 1'b1 ||
                    (!is_inst && we && mem_wdata_o !== wdata)) begin
                    mismatched++;
                    $display("FAIL grant_bus: addr=%h we=%b sel=%h wd=%h stall=%b want addr=%h sel=%h wd=%h",
                             mem_addr_o, mem_we_o, mem_sel_o, mem_wdata_o, stallreq_o,
                             addr, is_inst ? 4'hF : sel, wdata);
                end
                mem_ready_i = (wait_cyc != 0 && gcnt == wait_cyc);
            end else begin
                mem_ready_i = 1'b0;
            end
            compared++;
            if ((is_inst ? data_ack_o : inst_ack_o) !== 1'b0) begin
                mismatched++;
                $display("FAIL other_ack: inst_ack=%b data_ack=%b is_inst=%0d", inst_ack_o, data_ack_o, is_inst);
            end
            if ((is_inst ? inst_ack_o : data_ack_o) === 1'b1) begin
                got = 1;
                mem_ready_i = 1'b0;
                inst_req_i = 1'b0;
                data_req_i = 1'b0;
                got_e = sb.pop_front();
                compared++;
                if ((is_inst ? inst_rdata_o : data_rdata_o) !== got_e.rdata || err_o !== got_e.err) begin
                    mismatched++;
                    $display("FAIL ack_data: rdata=%h err=%b want rdata=%h err=%b",
                             is_inst ? inst_rdata_o : data_rdata_o, err_o, got_e.rdata, got_e.err);
                end
                compared++;
                if (lat != exp_g + 1 || gcnt != exp_g || stallreq_o !== 1'b0) begin
                    mismatched++;
                    $display("FAIL ack_timing: latency=%0d grant_cycles=%0d stall=%b want latency=%0d grant_cycles=%0d stall=0",
                             lat, gcnt, stallreq_o, exp_g + 1, exp_g);
                end
            end
        end
        if (!got) begin
            compared++; mismatched++;
            $display("FAIL ack_wait: no ack within 64 cycles, got 0 want 1");
            inst_req_i = 1'b0; data_req_i = 1'b0; mem_ready_i = 1'b0;
            sb.delete();
        end
        @(negedge clk);
        compared++;
        if (mem_ce_o !== 1'b0 || stallreq_o !== 1'b0 || inst_ack_o !== 1'b0 || data_ack_o !== 1'b0 || err_o !== 1'b0) begin
            mismatched++;
            $display("FAIL back_to_idle: ce=%b stall=%b iack=%b dack=%b err=%b want all 0",
                     mem_ce_o, stallreq_o, inst_ack_o, data_ack_o, err_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        inst_req_i = 0; data_req_i = 0; data_we_i = 0; mem_ready_i = 0;
        inst_addr_i = 0; data_addr_i = 0; data_wdata_i = 0; data_sel_i = 0; mem_rdata_i = 0;
        repeat (3) @(negedge clk);
        compared++;
        if ({mem_ce_o, mem_we_o, inst_ack_o, data_ack_o, err_o, stallreq_o} !== 6'b0 ||
            mem_addr_o !== 0 || mem_wdata_o !== 0 || mem_sel_o !== 0 ||
            inst_rdata_o !== 0 || data_rdata_o !== 0) begin
            mismatched++;
            $display("FAIL reset_state: ce=%b we=%b addr=%h sel=%h iack=%b dack=%b ird=%h drd=%h want all 0",
                     mem_ce_o, mem_we_o, mem_addr_o, mem_sel_o, inst_ack_o, data_ack_o, inst_rdata_o, data_rdata_o);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fetch();
        run_single(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 1, 32'h3401_1100);
    endtask

    task automatic test_store();
        run_single(1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b0011, 3, 32'h1234_5678);
    endtask

    task automatic test_timeout();
        run_single(1'b0, 1'b0, 32'h0000_0300, 32'h0, 4'hF, 0, 32'hFFFF_FFFF);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int acks = 0;
        bit order[6] = '{0, 0, 1, 0, 0, 1};
        for (int k = 0; k < 6; k++) begin
            e.is_inst = order[k];
            e.rdata   = 32'hA000_0000 + k;
            e.err     = 0;
            sb.push_back(e);
        end
        @(negedge clk);
        inst_req_i = 1; inst_addr_i = 32'h40;
        data_req_i = 1; data_we_i = 0; data_addr_i = 32'h80; data_sel_i = 4'b1100;
        for (int c = 0; c < 60 && acks < 6; c++) begin
            @(negedge clk);
            compared++;
            if (stallreq_o !== !(inst_ack_o | data_ack_o)) begin
                mismatched++;
                $display("FAIL arb_stall: stall=%b want %b", stallreq_o, !(inst_ack_o | data_ack_o));
            end
            if (mem_ce_o) begin
                compared++;
                if (sb.size() == 0 || mem_addr_o !== (sb[0].is_inst ? 32'h40 : 32'h80) ||
                    mem_sel_o !== (sb[0].is_inst ? 4'hF : 4'b1100)) begin
                    mismatched++;
                    $display("FAIL arb_grant: access %0d addr=%h sel=%h", acks, mem_addr_o, mem_sel_o);
                end
                mem_rdata_i = 32'hA000_0000 + acks;
                mem_ready_i = 1;
            end else begin
                mem_ready_i = 0;
            end
            if (inst_ack_o | data_ack_o) begin
                e = sb.pop_front();
                compared++;
                if (inst_ack_o !== e.is_inst || data_ack_o !== !e.is_inst || err_o !== 1'b0 ||
                    (e.is_inst ? inst_rdata_o : data_rdata_o) !== e.rdata) begin
                    mismatched++;
                    $display("FAIL arb_order: access %0d iack=%b dack=%b rdata=%h want inst=%0d rdata=%h",
                             acks, inst_ack_o, data_ack_o, e.is_inst ? inst_rdata_o : data_rdata_o, e.is_inst, e.rdata);
                end
                acks++;
                if (acks == 6) begin
                    inst_req_i = 0; data_req_i = 0;
                end
            end
        end
        compared++;
        if (acks != 6) begin
            mismatched++;
            $display("FAIL arb_count: acks=%0d want 6", acks);
            inst_req_i = 0; data_req_i = 0; sb.delete();
        end
        mem_ready_i = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int gcnt = 0;
        @(negedge clk);
        inst_req_i = 1; inst_addr_i = 32'h200;
        for (int c = 0; c < 10 && gcnt < 2; c++) begin
            @(negedge clk);
            if (mem_ce_o) gcnt++;
        end
        rst = 1'b0;
        #1;
        compared++;
        if (mem_ce_o !== 1'b0 || inst_ack_o !== 1'b0 || inst_rdata_o !== 32'h0 || gcnt != 2) begin
            mismatched++;
            $display("FAIL reset_mid: ce=%b iack=%b ird=%h grant_cycles=%0d want ce=0 iack=0 ird=0 grant_cycles=2",
                     mem_ce_o, inst_ack_o, inst_rdata_o, gcnt);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            compared++;
            if (inst_ack_o !== 1'b0 || mem_ce_o !== 1'b0) begin
                mismatched++;
                $display("FAIL reset_hold: iack=%b ce=%b want 0", inst_ack_o, mem_ce_o);
            end
        end
        inst_req_i = 0;
        rst = 1'b1;
        @(negedge clk);
        run_single(1'b1, 1'b0, 32'h0000_0044, 32'h0, 4'h0, 2, 32'h0BAD_F00D);
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
